// File: rtl/mcpu_ctrl.sv
// Multi-cycle RV32I control unit: walks each instruction through fetch/decode/execute/memory/writeback
// and decodes the datapath controls from the current state, the IR fields and MIO_ready.
module mcpu_ctrl #(
    parameter int unsigned WAIT_MAX     = 15,
    parameter int unsigned CNT_W        = 4,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       MIO_ready,
    input  logic [4:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchN,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRW,
    output logic       CPU_MIO,
    output logic [1:0] ALUSrc_A,
    output logic [1:0] ALUSrc_B,
    output logic [2:0] ImmSel,
    output logic [1:0] MemtoReg,
    output logic [1:0] PCSource,
    output logic [3:0] ALU_Control,
    output logic [3:0] state,
    output logic       bus_err
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX     = 4'd2,
        S_WB_ALU = 4'd3,
        S_MA     = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_LD  = 4'd7,
        S_BR     = 4'd8,
        S_JMP    = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_RS1   = 2'd1;
    localparam logic [1:0] SRC_A_OLDPC = 2'd2;
    localparam logic [1:0] SRC_B_RS2   = 2'd0;
    localparam logic [1:0] SRC_B_IMM   = 2'd1;
    localparam logic [1:0] SRC_B_FOUR  = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    // Where an unsupported opcode or branch Fun3 goes.
    localparam state_t BAD_OP_NEXT = ILLEGAL_TRAP ? S_TRAP : S_IF;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_phase;
    logic             wait_expired;

    assign state        = state_q;
    assign mem_phase    = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign wait_expired = !MIO_ready && (wait_cnt == CNT_W'(WAIT_MAX - 1));

    // State, wait-state counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IF;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (mem_phase) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (mem_phase && wait_expired) begin
                bus_err <= 1'b1;
            end
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchN     = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemRW       = 1'b0;
        CPU_MIO     = 1'b0;
        ALUSrc_A    = SRC_A_PC;
        ALUSrc_B    = SRC_B_RS2;
        ImmSel      = IMM_I;
        MemtoReg    = 2'd0;
        PCSource    = 2'd0;
        ALU_Control = ALU_ADD;

        case (state_q)
            S_IF: begin
                CPU_MIO  = 1'b1;
                ALUSrc_B = SRC_B_FOUR;
                IRWrite  = MIO_ready;
                PCWrite  = MIO_ready;
                if (MIO_ready) begin
                    state_d = S_ID;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_ID: begin
                // Branch target is precomputed into ALUOut here.
                ALUSrc_A = SRC_A_OLDPC;
                ALUSrc_B = SRC_B_IMM;
                ImmSel   = IMM_B;
                case (OPcode)
                    OP_R, OP_I, OP_LUI, OP_AUIPC: state_d = S_EX;
                    OP_LOAD, OP_STORE:            state_d = S_MA;
                    OP_BRANCH:                    state_d = S_BR;
                    OP_JAL, OP_JALR:              state_d = S_JMP;
                    default:                      state_d = BAD_OP_NEXT;
                endcase
            end
            S_EX: begin
                state_d = S_WB_ALU;
                case (OPcode)
                    OP_R: begin
                        ALUSrc_A    = SRC_A_RS1;
                        ALU_Control = {Fun7, Fun3};
                    end
                    OP_I: begin
                        ALUSrc_A    = SRC_A_RS1;
                        ALUSrc_B    = SRC_B_IMM;
                        ALU_Control = {(Fun3 == 3'b101) ? Fun7 : 1'b0, Fun3};
                    end
                    OP_LUI: begin
                        // rs1 is forced to x0 by the datapath, giving 0 + imm.
                        ALUSrc_A = SRC_A_RS1;
                        ALUSrc_B = SRC_B_IMM;
                        ImmSel   = IMM_U;
                    end
                    OP_AUIPC: begin
                        ALUSrc_A = SRC_A_OLDPC;
                        ALUSrc_B = SRC_B_IMM;
                        ImmSel   = IMM_U;
                    end
                    default: ;
                endcase
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                state_d  = S_IF;
            end
            S_MA: begin
                ALUSrc_A = SRC_A_RS1;
                ALUSrc_B = SRC_B_IMM;
                ImmSel   = (OPcode == OP_STORE) ? IMM_S : IMM_I;
                state_d  = (OPcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                CPU_MIO = 1'b1;
                if (MIO_ready) begin
                    state_d = S_WB_LD;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_MEM_WR: begin
                CPU_MIO = 1'b1;
                MemRW   = 1'b1;
                if (MIO_ready) begin
                    state_d = S_IF;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_WB_LD: begin
                RegWrite = 1'b1;
                MemtoReg = 2'd1;
                state_d  = S_IF;
            end
            S_BR: begin
                ALUSrc_A    = SRC_A_RS1;
                PCSource    = 2'd1;
                PCWriteCond = 1'b1;
                state_d     = S_IF;
                case (Fun3)
                    3'b000: ALU_Control = ALU_SUB;
                    3'b001: begin
                        ALU_Control = ALU_SUB;
                        BranchN     = 1'b1;
                    end
                    3'b100: begin
                        ALU_Control = ALU_SLT;
                        BranchN     = 1'b1;
                    end
                    3'b101: ALU_Control = ALU_SLT;
                    3'b110: begin
                        ALU_Control = ALU_SLTU;
                        BranchN     = 1'b1;
                    end
                    3'b111: ALU_Control = ALU_SLTU;
                    default: begin
                        PCWriteCond = 1'b0;
                        state_d     = BAD_OP_NEXT;
                    end
                endcase
            end
            S_JMP: begin
                RegWrite = 1'b1;
                MemtoReg = 2'd2;
                PCWrite  = 1'b1;
                ALUSrc_B = SRC_B_IMM;
                state_d  = S_IF;
                if (OPcode == OP_JAL) begin
                    ALUSrc_A = SRC_A_OLDPC;
                    ImmSel   = IMM_J;
                end else begin
                    ALUSrc_A = SRC_A_RS1;
                end
            end
            S_TRAP: ;
            default: state_d = S_IF;
        endcase

        // No write or bus request may escape while reset is held.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemRW       = 1'b0;
            CPU_MIO     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Randomised bench for mcpu_ctrl: an instruction-level model expands each instruction into its expected
// per-cycle control vectors for a trapping and a non-trapping instance; a monitor checks them at negedge.
module tb_mcpu_ctrl;

    localparam int WAIT_MAX = 15;

    localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EX = 4'd2, S_WBA = 4'd3, S_MA = 4'd4;
    localparam logic [3:0] S_MRD = 4'd5, S_MWR = 4'd6, S_WBL = 4'd7, S_BR = 4'd8, S_JMP = 4'd9;
    localparam logic [3:0] S_TRAP = 4'd10;

    localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LUI = 5'b01101, OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_LD = 5'b00000, OP_ST = 5'b01000, OP_BR = 5'b11000;
    localparam logic [4:0] OP_JAL = 5'b11011, OP_JALR = 5'b11001;
    localparam logic [4:0] OPS [9] = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_n;
        logic       ir_write;
        logic       reg_write;
        logic       mem_rw;
        logic       cpu_mio;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] imm_sel;
        logic [1:0] mem_to_reg;
        logic [1:0] pc_source;
        logic [3:0] alu_ctl;
        logic       bus_err;
    } ctl_t;

    typedef struct {
        ctl_t exp_a;
        ctl_t exp_b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mio = 1'b0;
    logic [4:0] op  = 5'd0;
    logic [2:0] f3  = 3'd0;
    logic       f7  = 1'b0;

    logic       a_pcw, a_pcwc, a_bn, a_irw, a_rw, a_mrw, a_mio, a_berr;
    logic       b_pcw, b_pcwc, b_bn, b_irw, b_rw, b_mrw, b_mio, b_berr;
    logic [1:0] a_sa, a_sb, a_m2r, a_pcs, b_sa, b_sb, b_m2r, b_pcs;
    logic [2:0] a_imm, b_imm;
    logic [3:0] a_alu, a_st, b_alu, b_st;
    ctl_t       out_a, out_b;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   m_bus       = 1'b0;

    always #5 clk = ~clk;

    mcpu_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(4), .ILLEGAL_TRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .MIO_ready(mio), .OPcode(op), .Fun3(f3), .Fun7(f7),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .BranchN(a_bn), .IRWrite(a_irw), .RegWrite(a_rw),
        .MemRW(a_mrw), .CPU_MIO(a_mio), .ALUSrc_A(a_sa), .ALUSrc_B(a_sb), .ImmSel(a_imm),
        .MemtoReg(a_m2r), .PCSource(a_pcs), .ALU_Control(a_alu), .state(a_st), .bus_err(a_berr)
    );

    mcpu_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(4), .ILLEGAL_TRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .MIO_ready(mio), .OPcode(op), .Fun3(f3), .Fun7(f7),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .BranchN(b_bn), .IRWrite(b_irw), .RegWrite(b_rw),
        .MemRW(b_mrw), .CPU_MIO(b_mio), .ALUSrc_A(b_sa), .ALUSrc_B(b_sb), .ImmSel(b_imm),
        .MemtoReg(b_m2r), .PCSource(b_pcs), .ALU_Control(b_alu), .state(b_st), .bus_err(b_berr)
    );

    assign out_a = {a_st, a_pcw, a_pcwc, a_bn, a_irw, a_rw, a_mrw, a_mio,
                    a_sa, a_sb, a_imm, a_m2r, a_pcs, a_alu, a_berr};
    assign out_b = {b_st, b_pcw, b_pcwc, b_bn, b_irw, b_rw, b_mrw, b_mio,
                    b_sa, b_sb, b_imm, b_m2r, b_pcs, b_alu, b_berr};

    // Monitor: one expected vector pair per cycle, checked away from the active edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            if (out_a !== e.exp_a) begin
                miscompares++;
                $display("FAIL trap_cfg vec %0d op=%b f3=%b: got %h want %h", vectors, op, f3, out_a, e.exp_a);
            end
            if (out_b !== e.exp_b) begin
                miscompares++;
                $display("FAIL nop_cfg vec %0d op=%b f3=%b: got %h want %h", vectors, op, f3, out_b, e.exp_b);
            end
        end
    end

    function automatic ctl_t st(logic [3:0] s);
        ctl_t c = '0;
        c.state = s;
        return c;
    endfunction

    function automatic ctl_t fetch(bit ready);
        ctl_t c = st(S_IF);
        c.cpu_mio  = 1'b1;
        c.src_b    = 2'd2;
        c.ir_write = ready;
        c.pc_write = ready;
        return c;
    endfunction

    function automatic ctl_t in_reset(ctl_t c);
        ctl_t r = c;
        r.pc_write      = 1'b0;
        r.pc_write_cond = 1'b0;
        r.ir_write      = 1'b0;
        r.reg_write     = 1'b0;
        r.mem_rw        = 1'b0;
        r.cpu_mio       = 1'b0;
        return r;
    endfunction

    function automatic bit rnd();
        return 1'($urandom);
    endfunction

    // Issue one clock of stimulus and queue what both instances must show during it.
    task automatic cyc(bit r, bit m, ctl_t a, ctl_t b);
        exp_t e;
        a.bus_err = m_bus;
        b.bus_err = m_bus;
        e.exp_a = r ? in_reset(a) : a;
        e.exp_b = r ? in_reset(b) : b;
        rst = r;
        mio = m;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Both instances time out alike: sit in TRAP with bus_err until reset.
    task automatic timeout_tail();
        m_bus = 1'b1;
        repeat ($urandom_range(1, 3)) cyc(1'b0, rnd(), st(S_TRAP), st(S_TRAP));
        cyc(1'b1, rnd(), st(S_TRAP), st(S_TRAP));
        m_bus = 1'b0;
    endtask

    // Bad opcode/Fun3: trapping instance locks up, the other returns to fetch.
    task automatic illegal_tail();
        int k = $urandom_range(1, 3);
        repeat (k) cyc(1'b0, 1'b0, st(S_TRAP), fetch(1'b0));
        cyc(1'b1, 1'b0, st(S_TRAP), fetch(1'b0));
    endtask

    task automatic wait_phase(ctl_t busy, int w, output bit to);
        int n = (w >= WAIT_MAX) ? WAIT_MAX : w;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, busy, busy);
        to = (w >= WAIT_MAX);
        if (to) timeout_tail();
    endtask

    task automatic run_instr(logic [4:0] o, logic [2:0] fn3, logic fn7, int w_if, int w_mem, bit rst_mid);
        ctl_t c;
        bit   to;
        op = o;
        f3 = fn3;
        f7 = fn7;
        wait_phase(fetch(1'b0), w_if, to);
        if (to) return;
        cyc(1'b0, 1'b1, fetch(1'b1), fetch(1'b1));
        c = st(S_ID);
        c.src_a   = 2'd2;
        c.src_b   = 2'd1;
        c.imm_sel = 3'd2;
        cyc(1'b0, rnd(), c, c);
        case (o)
            OP_R, OP_I, OP_LUI, OP_AUIPC: begin
                c = st(S_EX);
                c.src_a   = 2'd1;
                c.src_b   = 2'd1;
                c.imm_sel = 3'd4;
                if (o == OP_R) begin
                    c.src_b   = 2'd0;
                    c.imm_sel = 3'd0;
                    c.alu_ctl = {fn7, fn3};
                end else if (o == OP_I) begin
                    c.imm_sel = 3'd0;
                    c.alu_ctl = {(fn3 == 3'b101) ? fn7 : 1'b0, fn3};
                end else if (o == OP_AUIPC) begin
                    c.src_a = 2'd2;
                end
                cyc(1'b0, rnd(), c, c);
                c = st(S_WBA);
                c.reg_write = 1'b1;
                cyc(1'b0, rnd(), c, c);
            end
            OP_LD, OP_ST: begin
                c = st(S_MA);
                c.src_a   = 2'd1;
                c.src_b   = 2'd1;
                c.imm_sel = (o == OP_ST) ? 3'd1 : 3'd0;
                cyc(1'b0, rnd(), c, c);
                c = st((o == OP_LD) ? S_MRD : S_MWR);
                c.cpu_mio = 1'b1;
                c.mem_rw  = (o == OP_ST);
                if (rst_mid && o == OP_ST) begin
                    cyc(1'b1, rnd(), c, c);
                    return;
                end
                wait_phase(c, w_mem, to);
                if (to) return;
                cyc(1'b0, 1'b1, c, c);
                if (o == OP_LD) begin
                    c = st(S_WBL);
                    c.reg_write  = 1'b1;
                    c.mem_to_reg = 2'd1;
                    cyc(1'b0, rnd(), c, c);
                end
            end
            OP_BR: begin
                c = st(S_BR);
                c.src_a         = 2'd1;
                c.pc_source     = 2'd1;
                c.pc_write_cond = 1'b1;
                case (fn3)
                    3'b000: c.alu_ctl = 4'b1000;
                    3'b001: begin c.alu_ctl = 4'b1000; c.branch_n = 1'b1; end
                    3'b100: begin c.alu_ctl = 4'b0010; c.branch_n = 1'b1; end
                    3'b101: c.alu_ctl = 4'b0010;
                    3'b110: begin c.alu_ctl = 4'b0011; c.branch_n = 1'b1; end
                    3'b111: c.alu_ctl = 4'b0011;
                    default: c.pc_write_cond = 1'b0;
                endcase
                cyc(1'b0, rnd(), c, c);
                if (fn3 == 3'b010 || fn3 == 3'b011) illegal_tail();
            end
            OP_JAL, OP_JALR: begin
                c = st(S_JMP);
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'd2;
                c.pc_write   = 1'b1;
                c.src_b      = 2'd1;
                c.src_a      = (o == OP_JAL) ? 2'd2 : 2'd1;
                c.imm_sel    = (o == OP_JAL) ? 3'd3 : 3'd0;
                cyc(1'b0, rnd(), c, c);
            end
            default: illegal_tail();
        endcase
    endtask

    function automatic int pick_wait();
        int r = int'($urandom_range(0, 39));
        if (r == 39) return WAIT_MAX;
        if (r == 38) return WAIT_MAX - 1;
        if (r >= 32) return int'($urandom_range(1, 3));
        return 0;
    endfunction

    function automatic bit is_legal(logic [4:0] o);
        for (int i = 0; i < 9; i++) if (OPS[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    initial begin : driver
        logic [4:0] o;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, fetch(1'b0), fetch(1'b0));

        run_instr(OP_I, 3'b000, 1'b0, 0, 0, 1'b0);              // addi x1,x0,5
        run_instr(OP_LD, 3'b010, 1'b0, 0, 3, 1'b0);             // lw with 3 wait states
        run_instr(OP_R, 3'b000, 1'b0, WAIT_MAX, 0, 1'b0);       // fetch timeout
        run_instr(OP_R, 3'b000, 1'b1, WAIT_MAX - 1, 0, 1'b0);   // ready on the last allowed cycle
        run_instr(OP_ST, 3'b010, 1'b0, 0, WAIT_MAX - 1, 1'b0);
        run_instr(OP_LD, 3'b010, 1'b0, 0, WAIT_MAX, 1'b0);      // load timeout
        run_instr(OP_BR, 3'b001, 1'b0, 0, 0, 1'b0);             // bne
        run_instr(OP_BR, 3'b111, 1'b0, 0, 0, 1'b0);             // bgeu
        run_instr(5'b11111, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(OP_BR, 3'b010, 1'b0, 0, 0, 1'b0);
        run_instr(OP_ST, 3'b010, 1'b0, 0, 0, 1'b1);             // reset during MEM_WR
        run_instr(OP_I, 3'b101, 1'b1, 0, 0, 1'b0);              // srai
        run_instr(OP_LUI, 3'b000, 1'b0, 1, 0, 1'b0);
        run_instr(OP_AUIPC, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(OP_JAL, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(OP_JALR, 3'b000, 1'b0, 2, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 9) begin
                do o = 5'($urandom); while (is_legal(o));
            end else begin
                o = OPS[$urandom_range(0, 8)];
            end
            run_instr(o, 3'($urandom), rnd(), pick_wait(), pick_wait(), ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(posedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mcpu_ctrl.md
Name: mcpu_ctrl

Overview:
Multi-cycle control unit for the RV32I CPU core, the successor to the single-cycle controller. It sequences each instruction through fetch/decode/execute/memory/writeback states and drives the datapath enables cycle by cycle. It honours the MIO_ready memory handshake with parametrised wait-state tolerance and a bus-timeout trap. It sits between the instruction register and the multi-cycle datapath inside the CPU top.

Parameters:
WAIT_MAX, 15, maximum consecutive cycles a memory access may wait for MIO_ready before bus_err; legal range 1..(2^CNT_W)-1
CNT_W, 4, width of the wait-state counter
ILLEGAL_TRAP, 1, 1: unknown opcode enters TRAP; 0: unknown opcode is treated as NOP and returns to IF

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
MIO_ready  in  1  memory/IO has completed the current access this cycle
OPcode  in  5  inst[6:2] from the instruction register
Fun3  in  3  inst[14:12]
Fun7  in  1  inst[30]
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if (Zero ^ BranchN)
BranchN  out  1  inverts the branch condition
IRWrite  out  1  instruction register load
RegWrite  out  1  register file write
MemRW  out  1  1 = write, 0 = read
CPU_MIO  out  1  memory access request
ALUSrc_A  out  2  0 = PC, 1 = rs1, 2 = old PC
ALUSrc_B  out  2  0 = rs2, 1 = imm, 2 = constant 4
ImmSel  out  3  0 I, 1 S, 2 B, 3 J, 4 U
MemtoReg  out  2  0 = ALUOut, 1 = MDR, 2 = PC+4
PCSource  out  2  0 = ALU result, 1 = ALUOut register
ALU_Control  out  4  ADD 0000, SUB 1000, SLT 0010, SLTU 0011; otherwise {Fun7,Fun3}
state  out  4  current state, for debug
bus_err  out  1  sticky memory-timeout flag

Behaviour:
- States: IF=0, ID=1, EX=2, WB_ALU=3, MA=4, MEM_RD=5, MEM_WR=6, WB_LD=7, BR=8, JMP=9, TRAP=10. Encodings 11..15 go to IF on the next clock.
- Reset: rst=1 at a rising edge sets state=IF, wait_cnt=0, bus_err=0.
  - While rst=1, every write enable (PCWrite, PCWriteCond, IRWrite, RegWrite, MemRW) and CPU_MIO are forced to 0.
- Outputs are decoded combinationally from state, the IR fields and MIO_ready. Any signal not listed for a state is 0.
- IF:
  - Asserts CPU_MIO=1, MemRW=0, ALUSrc_A=0, ALUSrc_B=2, ALU_Control=ADD, PCSource=0.
  - IRWrite and PCWrite equal MIO_ready, so the PC advances exactly once.
  - On MIO_ready, go to ID. Otherwise stay and increment wait_cnt.
- Wait counter:
  - Active in IF, MEM_RD and MEM_WR. It clears on every state change.
  - If MIO_ready=0 while wait_cnt==WAIT_MAX-1, the next state is TRAP and bus_err is set.
  - MIO_ready=1 in that same cycle wins: the access completes and there is no trap.
- ID: ALUSrc_A=2, ALUSrc_B=1, ImmSel=B, ALU_Control=ADD, which precomputes the branch target into ALUOut. The next state is decoded from OPcode:
  - 01100 or 00100 or 01101 or 00101 → EX
  - 00000 or 01000 → MA
  - 11000 → BR
  - 11011 or 11001 → JMP
  - any other opcode → TRAP if ILLEGAL_TRAP, else IF
- EX:
  - R-type: ALUSrc_A=1, ALUSrc_B=0, ALU_Control={Fun7,Fun3}.
  - I-type: ALUSrc_A=1, ALUSrc_B=1, ImmSel=I, ALU_Control={Fun3==101 ? Fun7 : 0, Fun3}.
  - LUI: the ALU computes 0+imm, so ALUSrc_A=1 is used with rs1 forced to x0 in the datapath. ImmSel=U, ALU_Control=ADD.
  - AUIPC: ALUSrc_A=2, ImmSel=U, ALU_Control=ADD.
  - Next state is WB_ALU.
- WB_ALU: RegWrite=1, MemtoReg=0, then IF.
- MA: ALUSrc_A=1, ALUSrc_B=1, ImmSel=I for loads and S for stores, ALU_Control=ADD. Next state is MEM_RD for loads, MEM_WR for stores.
- MEM_RD: CPU_MIO=1, MemRW=0. Stays until MIO_ready, then goes to WB_LD.
- MEM_WR: CPU_MIO=1, MemRW=1. Stays until MIO_ready, then goes to IF.
- WB_LD: RegWrite=1, MemtoReg=1, then IF.
- BR: ALUSrc_A=1, ALUSrc_B=0, PCSource=1, PCWriteCond=1, then IF. ALU operation and BranchN by Fun3:
  - BEQ: SUB, BranchN=0
  - BNE: SUB, BranchN=1
  - BLT: SLT, BranchN=1
  - BGE: SLT, BranchN=0
  - BLTU: SLTU, BranchN=1
  - BGEU: SLTU, BranchN=0
  - Fun3 010 or 011 → TRAP if ILLEGAL_TRAP, else IF with no PC write.
- JMP: RegWrite=1, MemtoReg=2, PCWrite=1, PCSource=0, ALU_Control=ADD, then IF.
  - JAL: ALUSrc_A=2, ALUSrc_B=1, ImmSel=J.
  - JALR: ALUSrc_A=1, ALUSrc_B=1, ImmSel=I; the datapath clears bit 0 of the target.
- TRAP: all enables 0, CPU_MIO=0. Stays in TRAP until rst. bus_err holds its value.
- CPI with zero wait states: ALU 4, load 5, store 4, branch 3, jump 3. Each cycle of MIO_ready=0 adds one cycle.

Test Plan:
- Reset, then IF with MIO_ready=1 and IR=0x00500093 (addi x1,x0,5) → state sequence 0,1,2,3,0; IRWrite/PCWrite high only in the IF cycle; RegWrite=1 only in WB_ALU; ALU_Control=0000 in EX.
- lw x2,4(x1) with MIO_ready=0 for 3 cycles in MEM_RD → stays in 5 for 4 cycles; WB_LD asserts MemtoReg=1, RegWrite=1; bus_err=0.
- IF with MIO_ready held 0 and WAIT_MAX=15 → TRAP after exactly 15 cycles; bus_err=1 and stays 1; rst then returns state=0 with bus_err=0.
- MIO_ready rises in the cycle with wait_cnt=WAIT_MAX-1 → access completes, state=1, no trap.
- bne (Fun3=001) → BR asserts ALU_Control=1000, BranchN=1, PCWriteCond=1, PCSource=1; bgeu (Fun3=111) → ALU_Control=0011, BranchN=0.
- OPcode=11111 with ILLEGAL_TRAP=1 → ID then TRAP; with ILLEGAL_TRAP=0 → ID then IF with no enables; rst asserted mid-MEM_WR → next cycle state=0 with MemRW=0.
